// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding,
// requester count / index width and the 2-to-4 one-hot grant decoder.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Team 2-to-4 one-hot decoder: 00->0001, 01->0010, 10->0100, 11->1000.
  function automatic logic [NUM_REQ-1:0] dec2to4(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] onehot;
    case (idx)
      2'b00:   onehot = 4'b0001;
      2'b01:   onehot = 4'b0010;
      2'b10:   onehot = 4'b0100;
      2'b11:   onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the 4 requesting masters and the arbiter.
// master: requester side (drives req). slave: arbiter side (drives grants).
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_index;
  logic               grant_valid;
  logic               preempt;

  modport master (
    output req,
    input  grant,
    input  grant_index,
    input  grant_valid,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_index,
    output grant_valid,
    output preempt
  );

endinterface

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: finds the first set request bit when
// searching start_ptr_i, start_ptr_i+1, ... modulo 4.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand_s;

  // Walk the candidates in priority order and keep the first hit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_ptr_i;
    cand_s  = start_ptr_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s  = start_ptr_i + IDX_W'(k);
      idx_o   = (!found_o && req_i[cand_s]) ? cand_s : idx_o;
      found_o = found_o | req_i[cand_s];
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: round-robin arbiter sharing one resource among 4 requesters.
// Registered grant index, valid and one-hot grant vector; zero-bubble
// hand-over when the owner releases while others are waiting.
// Optional feature macro: ARB_TIMEOUT_EN -- revokes a grant held for
// HOLD_MAX contended cycles and pulses preempt for one cycle.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
)(
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_4_if.slave  bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (64'(1) << CNT_W) <= 64'(HOLD_MAX)) begin : g_param_check
    $error("rr_arbiter_4: HOLD_MAX must be 2..255 and fit in CNT_W bits");
  end

  arb_state_e         state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               preempt_q;

  logic [NUM_REQ-1:0] pick_req_s;
  logic               found_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               owner_req_s;
  logic               timeout_s;

  // While a grant is active the owner is excluded from the search, so a
  // release or a timeout always hands over to someone else. In GRANT the
  // pointer equals owner+1, so the search starts just past the owner.
  assign pick_req_s  = (state_q == GRANT) ? (bus.req & ~grant_q) : bus.req;
  assign owner_req_s = |(bus.req & grant_q);

  rr_pick_4 u_pick (
    .req_i       (pick_req_s),
    .start_ptr_i (ptr_q),
    .found_o     (found_s),
    .idx_o       (pick_idx_s)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             competitor_s;
  logic             contended_s;

  assign competitor_s = |(bus.req & ~grant_q);
  assign contended_s  = (state_q == GRANT) && owner_req_s && competitor_s;
  assign timeout_s    = contended_s && (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

  // Count contended hold cycles; restart on every new grant or when uncontested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= {CNT_W{1'b0}};
    end else if (contended_s && !timeout_s) begin
      hold_cnt_q <= hold_cnt_q + CNT_W'(1);
    end else begin
      hold_cnt_q <= {CNT_W{1'b0}};
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Arbitration FSM with registered grant outputs and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'b00;
      idx_q     <= 2'b00;
      valid_q   <= 1'b0;
      grant_q   <= 4'b0000;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_s) begin
            state_q <= GRANT;
            idx_q   <= pick_idx_s;
            valid_q <= 1'b1;
            grant_q <= dec2to4(pick_idx_s);
            ptr_q   <= pick_idx_s + 2'b01;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req_s || timeout_s) begin
            if (found_s) begin
              state_q   <= GRANT;
              idx_q     <= pick_idx_s;
              valid_q   <= 1'b1;
              grant_q   <= dec2to4(pick_idx_s);
              ptr_q     <= pick_idx_s + 2'b01;
              preempt_q <= timeout_s;
            end else begin
              // Nobody waiting: go idle, index keeps the last owner.
              state_q <= IDLE;
              valid_q <= 1'b0;
              grant_q <= 4'b0000;
            end
          end else begin
            state_q <= GRANT;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          grant_q <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_index = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.preempt     = preempt_q;

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one downstream resource among 4 requesters.
- Produces a registered 2-bit grant index plus its one-hot grant vector. The vector is generated by the team's 2-to-4 one-hot decoder: 00→0001, 01→0010, 10→0100, 11→1000.
- Sits between 4 requesting masters and a single shared datapath; the datapath consumes grant_index/grant_valid.

Parameters:
- HOLD_MAX, 16, maximum consecutive cycles one grant may be held while another requester waits (used only with ARB_TIMEOUT_EN); legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is sampled on clk.
- req  input  4  request per requester; bit i high = requester i wants the resource; must stay high until done.
- grant  output  4  one-hot registered grant; decode of grant_index when grant_valid=1, else 0000.
- grant_index  output  2  index of the current owner; holds its last value when idle.
- grant_valid  output  1  high while a grant is active.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout (always 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset values: grant=0000, grant_index=00, grant_valid=0, preempt=0, rotation pointer ptr=00 (requester 0 has highest priority), hold counter=0, state=IDLE.
- States:
  - IDLE: no owner.
  - GRANT: owner = grant_index.
- IDLE→GRANT: if req≠0 at edge N, then at edge N+1 grant_valid=1 and grant_index = first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Latency from request to grant is 1 cycle.
- GRANT, owner's req still high: grant is held and all outputs are stable.
- GRANT, owner's req low at an edge: owner is released on that edge.
  - Other requests pending: the next owner is granted on the same edge (zero bubble); the search starts at old owner+1.
  - No requests pending: return to IDLE with grant_valid=0 and grant=0000.
- Pointer update: on every new grant to index i, ptr ← i+1 (mod 4; 3 wraps to 0).
- One-hot invariant: grant always has at most one bit set, and grant == decode(grant_index) whenever grant_valid=1.
- A requester that drops req before being granted is simply skipped; there is no request latching.
- Reset asserted mid-grant: all outputs go to reset values immediately, with no waiting for clk. After release, arbitration restarts from ptr=00.
- The owner's re-asserted req after release competes normally; it now has the lowest priority.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro defined:
  - The hold counter increments each GRANT cycle in which some other req bit is high.
  - The counter clears on a new grant, and on cycles with no competitor.
  - When the counter reaches HOLD_MAX-1 and a competitor is pending, the current grant is revoked at the next edge and the next requester (round-robin from owner+1) is granted on that same edge.
  - preempt pulses high for exactly that one cycle.
- Without the macro: no counter is instantiated, preempt is tied to 0, and the owner holds the grant indefinitely while its req is high.

Decomposition:
- Shared package arb_pkg: state encoding (IDLE=1'b0, GRANT=1'b1), NUM_REQ=4, IDX_W=2.
- One sub-module, rr_pick_4: purely combinational function of (req, start_ptr) → (found, idx[1:0]).
- The one-hot grant vector reuses the team's existing 2-to-4 decoder, fed from grant_index and gated by grant_valid.

Test Plan:
- Reset: assert rst_n=0 mid-grant (grant=0100) → grant=0000, grant_valid=0, grant_index=00 before the next clk edge; after release, req=1000 → grant=1000 one cycle later.
- Single requester: req=0010 at edge N → grant=0010, grant_index=01 at N+1; drop req → grant=0000, grant_valid=0 at the following edge.
- Fairness rotation: req=1111 held; each owner drops for one cycle after 2 cycles → grant sequence 0001, 0010, 0100, 1000, 0001 (wrap), with no idle cycles between owners.
- Pointer/skip: ptr=10 after grant to 1; req=0011 → grant 0001 first (search 2,3,0). Also: req=0100 dropped before grant → never granted.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): owner 0 holds req high, req[2] high → at the 4th contended cycle preempt=1 and grant switches to 0100 on the same edge.
- Timeout disabled build: same stimulus → grant stays 0001 for 100 cycles, preempt never 1.
